// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_is_jump,
  input  logic        id_is_div,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_branch_taken,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        ex_mem_bubble,
  output logic        div_active,
  output logic [31:0] stall_cycles
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Issue cycle counts as the first EX cycle, so BUSY lasts DIV_CYCLES-1 cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);
  localparam bit               MULTI    = (DIV_CYCLES > 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;

  assign load_use = ex_mem_read && (ex_waddr != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_waddr)) ||
                     (id_use_rt && (id_rt == ex_waddr)));

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    div_active    = 1'b0;
    case (state)
      IDLE: begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end else begin
          if (id_is_jump) if_id_flush = 1'b1;
          if (id_is_div && MULTI) begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_bubble = 1'b1;
        div_active    = 1'b1;
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // Hold the whole pipeline frozen while reset is asserted.
    if (!rst_n) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_en      = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
      div_active    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!pc_en && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Watches register operand usage in ID, load and divide occupancy in EX, and taken branches/jumps.
- Drives the PC, IF/ID and ID/EX enables, the flush controls, and an EX/MEM bubble.
- Sequences the multi-cycle divider so the ID-stage register file and its WB bypass are never read for an operand that is not yet produced.

Parameters:
- DIV_CYCLES, 32, number of cycles a divide occupies EX (legal range 1..255).
- CNT_W, 8, width of the divide countdown counter; must hold DIV_CYCLES-1.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- id_is_jump  input  1  ID instruction is J/JAL.
- id_is_div  input  1  ID instruction is DIV/DIVU.
- ex_mem_read  input  1  EX instruction is a load.
- ex_waddr  input  5  destination register of the EX instruction.
- ex_branch_taken  input  1  EX resolved a taken branch.
- pc_en  output  1  PC register load enable.
- if_id_en  output  1  IF/ID register load enable.
- if_id_flush  output  1  IF/ID clears to a NOP next edge.
- id_ex_en  output  1  ID/EX register load enable.
- id_ex_flush  output  1  ID/EX clears to a NOP next edge.
- ex_mem_bubble  output  1  EX/MEM loads a NOP instead of the EX result.
- div_active  output  1  divider occupies EX, in state BUSY.
- stall_cycles  output  32  count of cycles with pc_en=0.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, cnt=0, stall_cycles=0.
  - While reset is asserted: pc_en=if_id_en=id_ex_en=0, all flushes/bubble=0, div_active=0.
- FSM states: IDLE, BUSY. Outputs are combinational from state and inputs; state, cnt and stall_cycles are registered.
- load_use = ex_mem_read && ex_waddr!=0 && ((id_use_rs && id_rs==ex_waddr) || (id_use_rt && id_rt==ex_waddr)).
- Default outputs in IDLE: pc_en=if_id_en=id_ex_en=1, all flushes/bubble=0.
- Priority in IDLE, highest first:
  1. ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_en=1 (PC takes the target via the external mux). Overrides load_use and jump.
  2. load_use: pc_en=0, if_id_en=0, id_ex_flush=1. Jump flush is suppressed; the jump re-evaluates next cycle.
  3. id_is_jump: if_id_flush=1 (no delay slot); pc_en=1.
- Divide issue:
  - Condition: IDLE && id_is_div && !ex_branch_taken && !load_use.
  - The div advances into ID/EX normally.
  - If DIV_CYCLES>1: next state BUSY, cnt loaded with DIV_CYCLES-2.
  - If DIV_CYCLES==1: remain IDLE.
- BUSY (div in EX):
  - pc_en=if_id_en=id_ex_en=0, ex_mem_bubble=1, div_active=1.
  - Branch/jump/load_use inputs are ignored. The EX instruction is the div, so ex_branch_taken and ex_mem_read are 0 by construction.
  - If cnt==0: next state IDLE. Else cnt decrements.
  - The div therefore holds EX for exactly DIV_CYCLES cycles. The last cycle is the first IDLE cycle: ex_mem_bubble=0 and the result passes to EX/MEM.
- stall_cycles:
  - Increments on every clock with rst_n=1 and pc_en=0.
  - Saturates at 0xFFFF_FFFF.
- Reset mid-BUSY: immediately returns to IDLE; no residual stall after release.
- Register $0: never causes a load-use stall.

Test Plan:
- Load-use: lw $5 in EX (ex_mem_read=1, ex_waddr=5), ID add with id_rs=5, id_use_rs=1 -> pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle; stall_cycles goes 0→1.
- Load to $0: ex_waddr=0, id_rs=0, id_use_rs=1 -> no stall; all enables 1.
- Branch beats load-use: ex_branch_taken=1 with a load_use match -> pc_en=1, if_id_flush=1, id_ex_flush=1; stall_cycles unchanged.
- Jump: id_is_jump=1, no hazards -> if_id_flush=1, pc_en=1 for one cycle. Jump with load_use -> if_id_flush=0 and a stall that cycle.
- Divide, DIV_CYCLES=4: id_is_div=1 at cycle N -> div_active=1 and all enables 0 in cycles N+1..N+3; IDLE at N+4 with ex_mem_bubble=0; stall_cycles=3.
- Reset mid-divide: assert rst_n=0 at cycle N+2 of the above, release -> first post-reset cycle has div_active=0, enables 1, stall_cycles=0.
